// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and defaults for the countdown timer
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN (periodic reload at terminal count)
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             zero_q, zero_n;
  logic             expired_q, expired_n;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      zero_q    <= 1'b1;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      zero_q    <= zero_n;
      expired_q <= expired_n;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= reload_n;
`endif
    end
  end

  // Load wins over decrement; a load always clears any pending expiry.
  always_comb begin
    state_n   = state_q;
    count_n   = count_q;
    expired_n = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_n  = reload_q;
`endif
    if (load) begin
      count_n = load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_n = load_value;
`endif
      state_n = (load_value != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (count_q > ONE) begin
        count_n = count_q - ONE;
      end else if (count_q == ONE) begin
        expired_n = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        count_n = reload_q;
`else
        count_n = '0;
        state_n = DONE;
`endif
      end
    end
    zero_n = (count_n == '0);
  end

  always_comb begin
    busy    = (state_q == RUN);
    count   = count_q;
    zero    = zero_q;
    expired = expired_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer (honours COUNTDOWN_TIMER_AUTO_RELOAD_EN)
module tb_countdown_timer;

  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         expired;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count),
    .busy       (busy),
    .zero       (zero),
    .expired    (expired)
  );

  always #5 clock = ~clock;

  // Model: remaining ticks, whether a run is active, and the last pulse.
  int m_count = 0;
  int m_reload = 0;
  bit m_run = 0;
  bit m_exp = 0;
  bit m_valid = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_count = 0; m_reload = 0; m_run = 0; m_exp = 0; m_valid = 1;
    end else if (load) begin
      m_count = int'(load_value);
      m_reload = int'(load_value);
      m_run = (load_value != 0);
      m_exp = 0;
    end else begin
      m_exp = 0;
      if (m_run && enable) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_exp = 1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          m_count = m_reload;
`else
          m_run = 0;
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_zero", int'(zero), int'(m_count == 0));
      chk("model_expired", int'(expired), int'(m_exp));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    step(2);
    chk("reset_count", int'(count), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_expired", int'(expired), 0);
    reset = 1'b0;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    load = 1'b1; load_value = 5'd3; enable = 1'b1;
    step(1);
    load = 1'b0;
    chk("ar_first", int'(count), 3);
    step(2);
    chk("ar_one", int'(count), 1);
    chk("ar_no_exp_yet", int'(expired), 0);
    step(1);
    chk("ar_reload", int'(count), 3);
    chk("ar_exp", int'(expired), 1);
    chk("ar_busy", int'(busy), 1);
    step(3);
    chk("ar_exp2", int'(expired), 1);
    chk("ar_zero_never", int'(zero), 0);
    load = 1'b1; load_value = 5'd0;
    step(1);
    load = 1'b0;
    chk("ar_load0_busy", int'(busy), 0);
    chk("ar_load0_exp", int'(expired), 0);
    step(3);
`else
    // Load 5, free-running enable
    load = 1'b1; load_value = 5'd5; enable = 1'b1;
    step(1);
    load = 1'b0;
    chk("t2_load", int'(count), 5);
    chk("t2_busy", int'(busy), 1);
    step(4);
    chk("t2_one", int'(count), 1);
    chk("t2_no_exp", int'(expired), 0);
    step(1);
    chk("t2_zero", int'(count), 0);
    chk("t2_exp", int'(expired), 1);
    chk("t2_busy_drop", int'(busy), 0);
    step(1);
    chk("t2_exp_once", int'(expired), 0);
    chk("t2_hold0", int'(count), 0);

    // Load 3 with enable low, then release
    load = 1'b1; load_value = 5'd3; enable = 1'b0;
    step(1);
    load = 1'b0;
    step(4);
    chk("t3_hold", int'(count), 3);
    chk("t3_busy", int'(busy), 1);
    enable = 1'b1;
    step(2);
    chk("t3_one", int'(count), 1);
    step(1);
    chk("t3_exp", int'(expired), 1);
    chk("t3_zero", int'(zero), 1);

    // Reload mid-run, then load 0
    load = 1'b1; load_value = 5'd7;
    step(1);
    load = 1'b0;
    step(5);
    chk("t4_at2", int'(count), 2);
    load = 1'b1; load_value = 5'd9;
    step(1);
    chk("t4_restart", int'(count), 9);
    chk("t4_no_exp", int'(expired), 0);
    load_value = 5'd0;
    step(1);
    load = 1'b0;
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_zero", int'(zero), 1);
    chk("t4_idle_exp", int'(expired), 0);
    step(3);
    chk("t4_idle_stays", int'(count), 0);

    // Max load, reset at 10
    load = 1'b1; load_value = 5'd31;
    step(1);
    load = 1'b0;
    chk("t5_max", int'(count), 31);
    step(21);
    chk("t5_at10", int'(count), 10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_exp", int'(expired), 0);

    // Reset on the terminal edge suppresses the pulse
    load = 1'b1; load_value = 5'd2;
    step(1);
    load = 1'b0;
    step(1);
    chk("t5b_one", int'(count), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5b_no_exp", int'(expired), 0);
    step(2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
